// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin mux arbiter.
// Optional feature macro used by the top level: MUX_ARB_LOCK_EN.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  // Arbiter FSM: IDLE = no grant outstanding, GRANT = one requester owns the mux.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Encode a one-hot (or zero) vector to its bit index; zero maps to index 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: finds the first set bit of mask scanning
// ptr+1, ptr+2, ... ptr+8 (mod 8). The current pointer position is checked last.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Scan candidates in rotating order and keep the first hit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters.
// Grant, select and valid are registered; y is d[sel] gated by valid.
// Optional feature: define MUX_ARB_LOCK_EN to add a lock input that inhibits
// hold-timer preemption while asserted.
//
// Request/grant protocol: req[i] is a level held high for as long as requester i
// wants the mux. A grant appears one clock after the request is sampled and stays
// until the holder drops req, or until it has held MAX_HOLD cycles while another
// requester waits (round-robin preemption). The holder must keep req high to keep
// the grant; dropping req releases the mux on the next edge with no idle gap when
// another requester is waiting.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             y,
  output logic             gnt_chg,
  output arb_state_t       dbg_state
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = (MAX_HOLD != 0) ? MAX_HOLD_C : {HOLD_W{1'b1}};

  arb_state_t        state, state_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [SEL_W-1:0]  sel_n;
  logic              valid_n;
  logic              chg_n;

  logic [N_REQ-1:0]  others;
  logic [N_REQ-1:0]  pick_mask;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              lock_eff;
  logic              hold_expired;

`ifdef MUX_ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  // Requesters other than the current holder; in IDLE gnt is zero so this is req.
  assign others    = req & ~gnt;
  assign pick_mask = (state == IDLE) ? req : others;

  // One picker serves both the initial grant and the hand-over to the next requester.
  rr_pick8 u_pick (
    .ptr   (ptr),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == MAX_HOLD_C) && !lock_eff;

  // Next-state logic: grant, release with zero-gap hand-over, hold-timer preemption.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    valid_n = valid;
    chg_n   = 1'b0;
    hold_n  = hold_cnt;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << pick_idx;
          valid_n = 1'b1;
          chg_n   = 1'b1;
          hold_n  = HOLD_W'(1);
          ptr_n   = pick_idx;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          if (pick_found) begin
            gnt_n   = N_REQ'(1) << pick_idx;
            chg_n   = 1'b1;
            hold_n  = HOLD_W'(1);
            ptr_n   = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
            hold_n  = '0;
          end
        end else if (hold_expired && pick_found) begin
          gnt_n  = N_REQ'(1) << pick_idx;
          chg_n  = 1'b1;
          hold_n = HOLD_W'(1);
          ptr_n  = pick_idx;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
        hold_n  = '0;
      end
    endcase
    sel_n = onehot_to_idx(gnt_n);
  end

  // State and output registers; ptr starts at 7 so the first search begins at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      gnt_chg  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= SEL_W'(N_REQ - 1);
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      valid    <= valid_n;
      gnt_chg  <= chg_n;
      hold_cnt <= hold_n;
      ptr      <= ptr_n;
    end
  end

  // Shared 8:1 mux output; sel is registered so y only moves with sel, valid or d.
  assign y         = valid & d[sel];
  assign dbg_state = state;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter (default MAX_HOLD=4).
// Build with MUX_ARB_LOCK_EN defined to exercise the lock input as well.
module tb_mux8_rr_arbiter;
  import mux8_arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] d;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       y;
  logic       gnt_chg;
  arb_state_t dbg_state;

  int checks;
  int failures;
  logic [2:0] exp_q[$];

  mux8_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .valid     (valid),
    .y         (y),
    .gnt_chg   (gnt_chg),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs are sampled on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic yy, input logic c);
    check({tag, ".gnt"},     32'(gnt),     32'(g));
    check({tag, ".sel"},     32'(sel),     32'(s));
    check({tag, ".valid"},   32'(valid),   32'(v));
    check({tag, ".y"},       32'(y),       32'(yy));
    check({tag, ".gnt_chg"}, 32'(gnt_chg), 32'(c));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 8'h00;
    d        = 8'b1000_1010;
`ifdef MUX_ARB_LOCK_EN
    lock     = 1'b0;
`endif
    step();
    step();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Single requester 0: one-cycle latency, y = d[0] = 0
    req = 8'h01;
    step();
    check_out("req01", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
    check("req01.state", 32'(dbg_state), 32'(GRANT));
    req = 8'h00;
    step();
    check_out("rel01", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // From reset pointer: req 0A grants 1, then dropping req[1] hands to 3 with no gap
    do_reset();
    req = 8'h0A;
    step();
    check_out("req0a", 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
    step();
    check_out("keep02", 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);
    req = 8'h08;
    step();
    check_out("hand08", 8'h08, 3'd3, 1'b1, 1'b1, 1'b1);

    // All requesting: 0..7,0 each held 4 cycles, gnt_chg every 4th cycle
    do_reset();
    for (int c = 0; c < 36; c++) exp_q.push_back(3'((c / 4) % 8));
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      logic [2:0] e;
      step();
      e = exp_q.pop_front();
      check($sformatf("rr%0d.sel", c), 32'(sel), 32'(e));
      check($sformatf("rr%0d.gnt_chg", c), 32'(gnt_chg), 32'((c % 4) == 0));
      check($sformatf("rr%0d.gnt", c), 32'(gnt), 32'(8'h01 << e));
    end

    // Holder 0 drops, requester 2 alone: hand-over, then never preempted
    req = 8'h04;
    step();
    check_out("hand04", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      check_out($sformatf("solo%0d", c), 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    end
    req = 8'h00;
    step();
    check_out("idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("idle.state", 32'(dbg_state), 32'(IDLE));

    // Asynchronous reset mid-grant, between clock edges
    req = 8'h04;
    step();
    check_out("pre_rst", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    req = 8'h80;
    step();
    check_out("req80", 8'h80, 3'd7, 1'b1, 1'b1, 1'b1);

    // Two requesters: holder 0 preempted after 4 cycles (or held under lock)
    req = 8'h00;
    step();
    req = 8'h03;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("lock%0d.gnt", c), 32'(gnt), 32'h01);
    end
    lock = 1'b0;
    step();
    check_out("unlock", 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
`else
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("pair%0d.gnt", c), 32'(gnt), 32'h01);
    end
    step();
    check_out("preempt", 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
